// File: rtl/ptrbank_pkg.sv
// Shared types for the pointer bank: operation codes, FSM states and the
// index-width derivation used to size op_idx / rd_idx.
package ptrbank_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LDL    = 3'd1,
    OP_LDH    = 3'd2,
    OP_LDW    = 3'd3,
    OP_INC    = 3'd4,
    OP_DEC    = 3'd5,
    OP_ADDREL = 3'd6,
    OP_RSVD   = 3'd7
  } op_code_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FIX  = 1'b1
  } state_e;

  // Index width for a bank of num_ptr registers; never narrower than 1 bit.
  function automatic int calc_idx_w(input int num_ptr);
    return (num_ptr <= 2) ? 1 : $clog2(num_ptr);
  endfunction

endpackage

// File: rtl/ptr_addsub.sv
// One byte slice of the pointer arithmetic: a + b + cin with carry out.
// Subtraction and signed offsets are expressed by the caller through b
// (all-ones for -1, sign-extension byte for the upper slice of ADDREL).
module ptr_addsub #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W:0] full;

  // Widened add so the carry falls out as the top bit.
  assign full = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
  assign {cout, sum} = full;

endmodule

// File: rtl/pointer_bank.sv
// Bank of NUM_PTR pointers, each two BYTE_W halves, with byte loads, word
// load, increment/decrement and signed relative add.
// Build option POINTER_BANK_PAGE_PENALTY_EN: a page-crossing ADDREL spends
// an extra FIX cycle repairing the high half (low half written first).
// Without it every operation completes in one cycle and op_ready stays 1.
module pointer_bank
  import ptrbank_pkg::*;
#(
  parameter int BYTE_W  = 8,
  parameter int NUM_PTR = 3,
  parameter int IDX_W   = calc_idx_w(NUM_PTR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [2:0]          op_code,
  input  logic [IDX_W-1:0]    op_idx,
  input  logic [2*BYTE_W-1:0] op_data,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [2*BYTE_W-1:0] rd_ptr,
  output logic                done,
  output logic                page_cross,
  output logic                wrap,
  output logic                err
);

  localparam int PTR_W = 2 * BYTE_W;

`ifdef POINTER_BANK_PAGE_PENALTY_EN
  localparam bit PAGE_PENALTY = 1'b1;
`else
  localparam bit PAGE_PENALTY = 1'b0;
`endif

  logic [PTR_W-1:0]         ptr_q [NUM_PTR];
  state_e                   state;
  logic [IDX_W-1:0]         fix_idx;
  logic                     fix_neg;
  logic                     fix_wrap;

  op_code_e                 op;
  logic                     idx_ok;
  logic                     bad_op;
  logic                     accept;
  logic [PTR_W-1:0]         cur_ptr;
  logic [BYTE_W-1:0]        fix_hi;
  logic signed [BYTE_W-1:0] rel_off;

  logic [BYTE_W-1:0]        lo_a, lo_b, lo_sum, hi_a, hi_b, hi_ext, hi_sum;
  logic                     lo_cin, lo_cout, hi_cin, hi_cout, sub_neg;
  logic                     wrap_c, cross_c, go_fix;

  logic [IDX_W-1:0]         wr_sel;
  logic                     wr_lo, wr_hi;
  logic [BYTE_W-1:0]        wr_lo_val, wr_hi_val;

  assign op       = op_code_e'(op_code);
  assign rel_off  = op_data[BYTE_W-1:0];
  assign op_ready = (state == ST_IDLE);
  assign accept   = op_valid && op_ready;
  assign bad_op   = !idx_ok || (op == OP_RSVD);

  // Register-file read ports: operation target, FIX target and external read.
  always_comb begin
    cur_ptr = '0;
    fix_hi  = '0;
    rd_ptr  = '0;
    idx_ok  = 1'b0;
    for (int i = 0; i < NUM_PTR; i++) begin
      if (op_idx == IDX_W'(i)) begin
        cur_ptr = ptr_q[i];
        idx_ok  = 1'b1;
      end
      if (fix_idx == IDX_W'(i)) fix_hi = ptr_q[i][PTR_W-1:BYTE_W];
      if (rd_idx == IDX_W'(i))  rd_ptr = ptr_q[i];
    end
  end

  // Low-slice operands and the sign/extension byte for the high slice.
  always_comb begin
    lo_a    = cur_ptr[BYTE_W-1:0];
    lo_b    = '0;
    lo_cin  = 1'b0;
    hi_ext  = '0;
    sub_neg = 1'b0;
    case (op)
      OP_INC: lo_cin = 1'b1;
      OP_DEC: begin
        lo_b    = '1;
        hi_ext  = '1;
        sub_neg = 1'b1;
      end
      OP_ADDREL: begin
        lo_b    = rel_off;
        hi_ext  = {BYTE_W{rel_off[BYTE_W-1]}};
        sub_neg = rel_off[BYTE_W-1];
      end
      default: ;
    endcase
  end

  // In FIX the high slice is reused for the deferred +1/-1 on the stored target.
  assign hi_a   = (state == ST_FIX) ? fix_hi : cur_ptr[PTR_W-1:BYTE_W];
  assign hi_b   = (state == ST_FIX) ? {BYTE_W{fix_neg}} : hi_ext;
  assign hi_cin = (state == ST_FIX) ? ~fix_neg : lo_cout;

  ptr_addsub #(.DATA_W(BYTE_W)) u_add_lo (
    .a(lo_a), .b(lo_b), .cin(lo_cin), .sum(lo_sum), .cout(lo_cout)
  );

  ptr_addsub #(.DATA_W(BYTE_W)) u_add_hi (
    .a(hi_a), .b(hi_b), .cin(hi_cin), .sum(hi_sum), .cout(hi_cout)
  );

  // A negative addend wraps when no carry leaves the top; a positive one when it does.
  assign wrap_c  = sub_neg ? ~hi_cout : hi_cout;
  assign cross_c = (hi_sum != cur_ptr[PTR_W-1:BYTE_W]);
  assign go_fix  = PAGE_PENALTY && accept && !bad_op && (op == OP_ADDREL) && cross_c;

  // Decode which halves of which pointer are written this cycle.
  always_comb begin
    wr_sel    = op_idx;
    wr_lo     = 1'b0;
    wr_hi     = 1'b0;
    wr_lo_val = lo_sum;
    wr_hi_val = hi_sum;
    if (state == ST_FIX) begin
      wr_sel = fix_idx;
      wr_hi  = 1'b1;
    end else if (accept && !bad_op) begin
      case (op)
        OP_LDL: begin
          wr_lo     = 1'b1;
          wr_lo_val = op_data[BYTE_W-1:0];
        end
        OP_LDH: begin
          wr_hi     = 1'b1;
          wr_hi_val = op_data[BYTE_W-1:0];
        end
        OP_LDW: begin
          wr_lo     = 1'b1;
          wr_hi     = 1'b1;
          wr_lo_val = op_data[BYTE_W-1:0];
          wr_hi_val = op_data[PTR_W-1:BYTE_W];
        end
        OP_INC, OP_DEC: begin
          wr_lo = 1'b1;
          wr_hi = 1'b1;
        end
        OP_ADDREL: begin
          wr_lo = 1'b1;
          wr_hi = !go_fix;
        end
        default: ;
      endcase
    end
  end

  // Pointer storage, FSM and the registered completion pulse with its flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PTR; i++) ptr_q[i] <= '0;
      state      <= ST_IDLE;
      done       <= 1'b0;
      page_cross <= 1'b0;
      wrap       <= 1'b0;
      err        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PTR; i++) begin
        if (wr_sel == IDX_W'(i)) begin
          if (wr_lo) ptr_q[i][BYTE_W-1:0]     <= wr_lo_val;
          if (wr_hi) ptr_q[i][PTR_W-1:BYTE_W] <= wr_hi_val;
        end
      end
      done       <= 1'b0;
      page_cross <= 1'b0;
      wrap       <= 1'b0;
      err        <= 1'b0;
      case (state)
        ST_FIX: begin
          state      <= ST_IDLE;
          done       <= 1'b1;
          page_cross <= 1'b1;
          wrap       <= fix_wrap;
        end
        default: begin
          if (op_valid) begin
            if (bad_op) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (go_fix) begin
              state <= ST_FIX;
            end else begin
              done <= 1'b1;
              if (op == OP_INC || op == OP_DEC) wrap <= wrap_c;
              if (op == OP_ADDREL) begin
                page_cross <= cross_c;
                wrap       <= wrap_c;
              end
            end
          end
        end
      endcase
    end
  end

  // Context for the deferred high-half fix, captured when FIX is entered.
  always_ff @(posedge clk) begin
    if (go_fix) begin
      fix_idx  <= op_idx;
      fix_neg  <= sub_neg;
      fix_wrap <= wrap_c;
    end
  end

endmodule

// File: tb/tb_pointer_bank.sv
// Directed bench for pointer_bank: default build (BYTE_W=8, NUM_PTR=3) plus a
// BYTE_W=4 / NUM_PTR=5 instance. Expectations follow the page-penalty macro.
`timescale 1ns/1ps
module tb_pointer_bank;

`ifdef POINTER_BANK_PAGE_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  localparam logic [2:0] C_NOP = 3'd0, C_LDL = 3'd1, C_LDH = 3'd2, C_LDW = 3'd3,
                         C_INC = 3'd4, C_DEC = 3'd5, C_ADD = 3'd6, C_RSV = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready;
  logic [2:0]  op_code;
  logic [1:0]  op_idx, rd_idx;
  logic [15:0] op_data, rd_ptr;
  logic        done, page_cross, wrap, err;

  logic        s_op_valid, s_op_ready;
  logic [2:0]  s_op_code;
  logic [2:0]  s_op_idx, s_rd_idx;
  logic [7:0]  s_op_data, s_rd_ptr;
  logic        s_done, s_page_cross, s_wrap, s_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pointer_bank #(.BYTE_W(8), .NUM_PTR(3)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_idx(op_idx), .op_data(op_data),
    .rd_idx(rd_idx), .rd_ptr(rd_ptr), .done(done),
    .page_cross(page_cross), .wrap(wrap), .err(err)
  );

  pointer_bank #(.BYTE_W(4), .NUM_PTR(5)) dut_s (
    .clk(clk), .rst(rst), .op_valid(s_op_valid), .op_ready(s_op_ready),
    .op_code(s_op_code), .op_idx(s_op_idx), .op_data(s_op_data),
    .rd_idx(s_rd_idx), .rd_ptr(s_rd_ptr), .done(s_done),
    .page_cross(s_page_cross), .wrap(s_wrap), .err(s_err)
  );

  // Issue one op and wait (bounded) for its done pulse; lat=-1 on timeout.
  task automatic run_op(input logic [2:0] c, input logic [1:0] i,
                        input logic [15:0] d, output int lat);
    op_code = c; op_idx = i; op_data = d; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic peek(input logic [1:0] i, output logic [15:0] v);
    rd_idx = i; #1;
    v = rd_ptr;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b expected 0", done); end
    tests++; if ({page_cross, wrap, err} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b expected 000", {page_cross, wrap, err}); end
    rst = 1'b0;
    #1;
    tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b expected 1", op_ready); end
    tests++; if (s_op_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_small: got %b expected 1", s_op_ready); end
    for (int i = 0; i < 3; i++) begin
      peek(2'(i), v);
      tests++; if (v !== 16'h0000) begin fails++; $display("FAIL rst_ptr%0d: got %h expected 0000", i, v); end
    end
  endtask

  task automatic test_reset_priority;
    int lat;
    logic [15:0] v;
    run_op(C_LDW, 2'd0, 16'h5555, lat);
    op_code = C_LDW; op_idx = 2'd0; op_data = 16'hAAAA; op_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; rst = 1'b0;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rstprio_done: got %b expected 0", done); end
    peek(2'd0, v);
    tests++; if (v !== 16'h0000) begin fails++; $display("FAIL rstprio_ptr: got %h expected 0000", v); end
  endtask

  task automatic test_loads;
    int lat;
    logic [15:0] v;
    run_op(C_LDW, 2'd0, 16'h1234, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL ldw_lat: got %0d expected 1", lat); end
    run_op(C_LDL, 2'd0, 16'hABAB, lat);
    peek(2'd0, v);
    tests++; if (v !== 16'h12AB) begin fails++; $display("FAIL ldl_val: got %h expected 12ab", v); end
    run_op(C_LDH, 2'd0, 16'hCDCD, lat);
    peek(2'd0, v);
    tests++; if (v !== 16'hCDAB) begin fails++; $display("FAIL ldh_val: got %h expected cdab", v); end
  endtask

  task automatic test_page_cross;
    int lat;
    logic [15:0] v;
    run_op(C_LDW, 2'd1, 16'h12F0, lat);
    peek(2'd1, v);
    tests++; if (v !== 16'h12F0) begin fails++; $display("FAIL pc_load: got %h expected 12f0", v); end
    rd_idx = 2'd1;
    op_code = C_ADD; op_idx = 2'd1; op_data = 16'h0020; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    v = PEN ? 16'h1210 : 16'h1310;
    tests++; if (rd_ptr !== v) begin fails++; $display("FAIL pc_first_rd: got %h expected %h", rd_ptr, v); end
    tests++; if (op_ready !== !PEN) begin fails++; $display("FAIL pc_first_ready: got %b expected %b", op_ready, !PEN); end
    tests++; if (done !== !PEN) begin fails++; $display("FAIL pc_first_done: got %b expected %b", done, !PEN); end
    tests++; if (page_cross !== !PEN) begin fails++; $display("FAIL pc_first_flag: got %b expected %b", page_cross, !PEN); end
    @(posedge clk); #1;
    tests++; if (rd_ptr !== 16'h1310) begin fails++; $display("FAIL pc_second_rd: got %h expected 1310", rd_ptr); end
    tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL pc_second_ready: got %b expected 1", op_ready); end
    tests++; if (done !== PEN) begin fails++; $display("FAIL pc_second_done: got %b expected %b", done, PEN); end
    tests++; if (page_cross !== PEN) begin fails++; $display("FAIL pc_second_flag: got %b expected %b", page_cross, PEN); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL pc_second_wrap: got %b expected 0", wrap); end
  endtask

  task automatic test_addrel_neg;
    int lat;
    logic [15:0] v;
    run_op(C_LDW, 2'd0, 16'h0205, lat);
    run_op(C_ADD, 2'd0, 16'h00F0, lat);
    tests++; if (lat !== (PEN ? 2 : 1)) begin fails++; $display("FAIL neg_cross_lat: got %0d expected %0d", lat, PEN ? 2 : 1); end
    tests++; if ({page_cross, wrap} !== 2'b10) begin fails++; $display("FAIL neg_cross_flags: got %b expected 10", {page_cross, wrap}); end
    peek(2'd0, v);
    tests++; if (v !== 16'h01F5) begin fails++; $display("FAIL neg_cross_val: got %h expected 01f5", v); end
    run_op(C_LDW, 2'd0, 16'h0215, lat);
    run_op(C_ADD, 2'd0, 16'h00F0, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL neg_same_lat: got %0d expected 1", lat); end
    tests++; if (page_cross !== 1'b0) begin fails++; $display("FAIL neg_same_flag: got %b expected 0", page_cross); end
    peek(2'd0, v);
    tests++; if (v !== 16'h0205) begin fails++; $display("FAIL neg_same_val: got %h expected 0205", v); end
  endtask

  task automatic test_wrap;
    int lat;
    logic [15:0] v;
    run_op(C_LDW, 2'd2, 16'hFFFF, lat);
    run_op(C_INC, 2'd2, 16'h0000, lat);
    tests++; if (wrap !== 1'b1) begin fails++; $display("FAIL inc_wrap_flag: got %b expected 1", wrap); end
    peek(2'd2, v);
    tests++; if (v !== 16'h0000) begin fails++; $display("FAIL inc_wrap_val: got %h expected 0000", v); end
    run_op(C_DEC, 2'd2, 16'h0000, lat);
    tests++; if (wrap !== 1'b1) begin fails++; $display("FAIL dec_wrap_flag: got %b expected 1", wrap); end
    peek(2'd2, v);
    tests++; if (v !== 16'hFFFF) begin fails++; $display("FAIL dec_wrap_val: got %h expected ffff", v); end
    run_op(C_LDW, 2'd2, 16'h00FF, lat);
    run_op(C_INC, 2'd2, 16'h0000, lat);
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL inc_carry_flag: got %b expected 0", wrap); end
    peek(2'd2, v);
    tests++; if (v !== 16'h0100) begin fails++; $display("FAIL inc_carry_val: got %h expected 0100", v); end
    run_op(C_LDW, 2'd2, 16'hFFF0, lat);
    run_op(C_ADD, 2'd2, 16'h0020, lat);
    tests++; if ({page_cross, wrap} !== 2'b11) begin fails++; $display("FAIL rel_wrap_up_flags: got %b expected 11", {page_cross, wrap}); end
    peek(2'd2, v);
    tests++; if (v !== 16'h0010) begin fails++; $display("FAIL rel_wrap_up_val: got %h expected 0010", v); end
    run_op(C_LDW, 2'd2, 16'h0005, lat);
    run_op(C_ADD, 2'd2, 16'h00F0, lat);
    tests++; if ({page_cross, wrap} !== 2'b11) begin fails++; $display("FAIL rel_wrap_dn_flags: got %b expected 11", {page_cross, wrap}); end
    peek(2'd2, v);
    tests++; if (v !== 16'hFFF5) begin fails++; $display("FAIL rel_wrap_dn_val: got %h expected fff5", v); end
  endtask

  task automatic test_err;
    int lat;
    logic [15:0] v0, v1, v2;
    run_op(C_LDW, 2'd0, 16'h1111, lat);
    run_op(C_LDW, 2'd1, 16'h2222, lat);
    run_op(C_LDW, 2'd2, 16'h3333, lat);
    run_op(C_LDW, 2'd3, 16'hDEAD, lat);
    tests++; if (lat !== 1 || err !== 1'b1) begin fails++; $display("FAIL err_idx: got lat %0d err %b expected lat 1 err 1", lat, err); end
    run_op(C_RSV, 2'd0, 16'hBEEF, lat);
    tests++; if (lat !== 1 || err !== 1'b1) begin fails++; $display("FAIL err_op7: got lat %0d err %b expected lat 1 err 1", lat, err); end
    run_op(C_NOP, 2'd1, 16'hBEEF, lat);
    tests++; if (lat !== 1 || {page_cross, wrap, err} !== 3'b000) begin fails++; $display("FAIL nop_flags: got lat %0d flags %b expected lat 1 flags 000", lat, {page_cross, wrap, err}); end
    peek(2'd0, v0); peek(2'd1, v1); peek(2'd2, v2);
    tests++; if ({v0, v1, v2} !== 48'h1111_2222_3333) begin fails++; $display("FAIL err_unchanged: got %h %h %h expected 1111 2222 3333", v0, v1, v2); end
  endtask

  task automatic test_reset_in_fix;
    int lat;
    logic [15:0] v;
    run_op(C_LDW, 2'd1, 16'h12F0, lat);
    op_code = C_ADD; op_idx = 2'd1; op_data = 16'h0020; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL fixrst_done: got %b expected 0", done); end
    tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL fixrst_ready: got %b expected 1", op_ready); end
    peek(2'd1, v);
    tests++; if (v !== 16'h0000) begin fails++; $display("FAIL fixrst_ptr: got %h expected 0000", v); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL fixrst_late_done: got %b expected 0", done); end
    run_op(C_INC, 2'd1, 16'h0000, lat);
    peek(2'd1, v);
    tests++; if (lat !== 1 || v !== 16'h0001) begin fails++; $display("FAIL fixrst_after: got lat %0d ptr %h expected lat 1 ptr 0001", lat, v); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [15:0] v;
    run_op(C_LDW, 2'd2, 16'h0010, lat);
    op_code = C_INC; op_idx = 2'd2; op_data = 16'h0000; op_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done%0d: got %b expected 1", k, done); end
    end
    op_valid = 1'b0;
    peek(2'd2, v);
    tests++; if (v !== 16'h0014) begin fails++; $display("FAIL b2b_val: got %h expected 0014", v); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b expected 0", done); end
  endtask

  task automatic test_small_build;
    s_rd_idx = 3'd4;
    s_op_code = C_LDW; s_op_idx = 3'd4; s_op_data = 8'hFF; s_op_valid = 1'b1;
    @(posedge clk); #1;
    tests++; if (s_done !== 1'b1 || s_rd_ptr !== 8'hFF) begin fails++; $display("FAIL small_ldw: got done %b ptr %h expected done 1 ptr ff", s_done, s_rd_ptr); end
    s_op_code = C_INC;
    @(posedge clk); #1;
    s_op_valid = 1'b0;
    tests++; if (s_done !== 1'b1 || s_wrap !== 1'b1) begin fails++; $display("FAIL small_inc_flags: got done %b wrap %b expected 1 1", s_done, s_wrap); end
    tests++; if (s_rd_ptr !== 8'h00) begin fails++; $display("FAIL small_inc_val: got %h expected 00", s_rd_ptr); end
    s_op_code = C_LDW; s_op_idx = 3'd5; s_op_data = 8'h55; s_op_valid = 1'b1;
    @(posedge clk); #1;
    s_op_valid = 1'b0;
    tests++; if (s_err !== 1'b1 || s_rd_ptr !== 8'h00) begin fails++; $display("FAIL small_err: got err %b ptr %h expected err 1 ptr 00", s_err, s_rd_ptr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_idx = '0; op_data = '0; rd_idx = '0;
    s_op_valid = 1'b0; s_op_code = 3'd0; s_op_idx = '0; s_op_data = '0; s_rd_idx = '0;
    test_reset;
    test_reset_priority;
    test_loads;
    test_page_cross;
    test_addrel_neg;
    test_wrap;
    test_err;
    test_reset_in_fix;
    test_back_to_back;
    test_small_build;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
